ctrl_seq: RTL and testbench
===========================

CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 Parameter NTAPS, default 16, sets the number of MAC convolution cycles per allocation entry (≥1).
REQ-002 Parameter NLIST, default 4, sets the number of allocation-list entries per channel (≥1).
REQ-003 Parameter NCH, default 2, sets the number of audio channels per frame (≥1).
REQ-004 Port clk  in  1  single clock; all state updates occur on its rising edge.
REQ-005 Port rst  in  1  synchronous, active-high reset.
REQ-006 Port start  in  1  frame start request, sampled only in IDLE.
REQ-007 Port err_en  in  1  error write-back enable, latched at frame start.
REQ-008 Ports in_valid (in, 1) and in_ready (out, 1) form the new-sample handshake from the audio bus.
REQ-009 Ports out_valid (out, 1) and out_ready (in, 1) form the output-sample handshake to the system.
REQ-010 Ports pc_clr, pc_incr, fetch, h_init, a_init, cnt, res_err, rf_rw, get_reg, new_in, new_out are 1-bit datapath strobes (out).
REQ-011 Port tap_idx  out  $clog2(NTAPS) (min 1)  current convolution tap.
REQ-012 Port lst_idx  out  $clog2(NLIST) (min 1)  current allocation-list entry.
REQ-013 Port ch_idx  out  $clog2(NCH) (min 1)  current channel.
REQ-014 Ports busy (out, 1) = state≠IDLE and done (out, 1) = one-cycle end-of-frame pulse.

Function
REQ-015 The block SHALL be a registered Moore FSM with states IDLE, ALLOC, LOAD, CONV, RES, ERR, INCR, OUT, IN; strobes decode from the state register, gated by the handshakes only where stated.
REQ-016 IDLE: all strobes 0; start=1 -> ALLOC, clearing lst_idx, ch_idx, tap_idx and latching err_en.
REQ-017 ALLOC: fetch=h_init=1 for 1 cycle -> LOAD.
REQ-018 LOAD: a_init=get_reg=1 for 1 cycle -> CONV with tap_idx=0.
REQ-019 CONV: cnt=1 for exactly NTAPS cycles; tap_idx increments 0..NTAPS-1 and then moves to RES; NTAPS=1 gives one CONV cycle.
REQ-020 RES: res_err=rf_rw=1 for 1 cycle -> ERR if latched err_en=1, else -> INCR.
REQ-021 ERR: rf_rw=1, res_err=0 for 1 cycle -> INCR.
REQ-022 INCR: pc_incr=1 for 1 cycle; if lst_idx<NLIST-1, increment lst_idx -> ALLOC; else -> OUT.
REQ-023 OUT: out_valid=1 held until out_ready=1; the transfer cycle asserts new_out=1 -> IN; the FSM stalls indefinitely with no strobes while out_ready=0.
REQ-024 IN: in_ready=1 held until in_valid=1; the transfer cycle asserts pc_clr=rf_rw=get_reg=new_in=1 and clears lst_idx.
REQ-025 After the IN transfer: if ch_idx<NCH-1, increment ch_idx -> ALLOC; else pulse done=1 and go to IDLE.
REQ-026 Per-entry latency SHALL be 5+NTAPS cycles (err_en=1) or 4+NTAPS (err_en=0); a stall-free channel adds 2 cycles (OUT, IN).
REQ-027 in_valid and out_ready asserted outside IN/OUT SHALL be ignored; in_ready/out_valid SHALL be 0 outside IN/OUT.
REQ-028 start while busy SHALL be ignored; err_en changes mid-frame SHALL have no effect.
REQ-029 At most one of pc_clr, pc_incr SHALL be high in any cycle; the index counters SHALL never exceed NTAPS-1/NLIST-1/NCH-1.
REQ-030 done and start in the same cycle: done is issued in IN, so the start is sampled on the following IDLE cycle, with no lost start while start is held.

Reset
REQ-031 rst=1 at any edge, including mid-frame or mid-stall, SHALL force IDLE, clear all indices and latched err_en, and drive all strobes, in_ready, out_valid, busy and done to 0 on the next cycle.
REQ-032 rst SHALL take priority over start and over all handshakes in the same cycle.

Verification
REQ-033 NTAPS=4, NLIST=2, NCH=1, err_en=1, out_ready=in_valid=1: start -> cnt high 4 cycles per entry, pc_incr pulses at cycles 9 and 18 after start, new_out at 19, new_in at 20, done at 20.
REQ-034 Same config with err_en=0: ERR is skipped, rf_rw is high only in RES and IN, and done comes at cycle 18.
REQ-035 NCH=2: ch_idx goes 0 then 1, with two new_out and two new_in pulses and a single done after the second IN.
REQ-036 Hold out_ready=0 for 10 cycles in OUT: out_valid stays 1, with no strobes and indices unchanged; release -> new_out in the release cycle.
REQ-037 Assert rst in CONV at tap_idx=2: the next cycle is IDLE with all outputs 0; a subsequent start runs a full correct frame.
REQ-038 NTAPS=1, NLIST=1: one CONV cycle; lst_idx and tap_idx stay 0; per-entry latency is 6 cycles.

Source files
------------

// File: rtl/ctrl_seq.sv
// Frame sequencer for the MAC convolution datapath.
// One registered FSM walks channels, list entries and taps.
module ctrl_seq #(
  parameter int NTAPS = 16,
  parameter int NLIST = 4,
  parameter int NCH   = 2,
  localparam int TW = (NTAPS > 1) ? $clog2(NTAPS) : 1,
  localparam int LW = (NLIST > 1) ? $clog2(NLIST) : 1,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          err_en,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          pc_clr,
  output logic          pc_incr,
  output logic          fetch,
  output logic          h_init,
  output logic          a_init,
  output logic          cnt,
  output logic          res_err,
  output logic          rf_rw,
  output logic          get_reg,
  output logic          new_in,
  output logic          new_out,
  output logic [TW-1:0] tap_idx,
  output logic [LW-1:0] lst_idx,
  output logic [CW-1:0] ch_idx,
  output logic          busy,
  output logic          done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ALLOC,
    S_LOAD,
    S_CONV,
    S_RES,
    S_ERR,
    S_INCR,
    S_OUT,
    S_IN
  } state_t;

  localparam logic [TW-1:0] TAP_LAST = TW'(NTAPS - 1);
  localparam logic [LW-1:0] LST_LAST = LW'(NLIST - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(NCH - 1);

  state_t          state;
  state_t          state_nxt;
  logic [TW-1:0]   tap_nxt;
  logic [LW-1:0]   lst_nxt;
  logic [CW-1:0]   ch_nxt;
  logic            err_q;
  logic            err_nxt;
  logic            out_xfer;
  logic            in_xfer;

  // a reset cycle never completes a handshake
  assign out_xfer = out_ready & ~rst;
  assign in_xfer  = in_valid & ~rst;
  assign busy     = (state != S_IDLE);

  // state, index counters and latched error-enable
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      tap_idx <= '0;
      lst_idx <= '0;
      ch_idx  <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      tap_idx <= tap_nxt;
      lst_idx <= lst_nxt;
      ch_idx  <= ch_nxt;
      err_q   <= err_nxt;
    end
  end

  // next state, counter updates and strobe decode
  always_comb begin
    state_nxt = state;
    tap_nxt   = tap_idx;
    lst_nxt   = lst_idx;
    ch_nxt    = ch_idx;
    err_nxt   = err_q;
    pc_clr    = 1'b0;
    pc_incr   = 1'b0;
    fetch     = 1'b0;
    h_init    = 1'b0;
    a_init    = 1'b0;
    cnt       = 1'b0;
    res_err   = 1'b0;
    rf_rw     = 1'b0;
    get_reg   = 1'b0;
    new_in    = 1'b0;
    new_out   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_ALLOC;
          tap_nxt   = '0;
          lst_nxt   = '0;
          ch_nxt    = '0;
          err_nxt   = err_en;
        end
      end
      S_ALLOC: begin
        fetch     = 1'b1;
        h_init    = 1'b1;
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        a_init    = 1'b1;
        get_reg   = 1'b1;
        tap_nxt   = '0;
        state_nxt = S_CONV;
      end
      S_CONV: begin
        cnt = 1'b1;
        if (tap_idx == TAP_LAST) begin
          tap_nxt   = '0;
          state_nxt = S_RES;
        end else begin
          tap_nxt = tap_idx + 1'b1;
        end
      end
      S_RES: begin
        res_err   = 1'b1;
        rf_rw     = 1'b1;
        state_nxt = err_q ? S_ERR : S_INCR;
      end
      S_ERR: begin
        rf_rw     = 1'b1;
        state_nxt = S_INCR;
      end
      S_INCR: begin
        pc_incr = 1'b1;
        if (lst_idx != LST_LAST) begin
          lst_nxt   = lst_idx + 1'b1;
          state_nxt = S_ALLOC;
        end else begin
          state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_xfer) begin
          new_out   = 1'b1;
          state_nxt = S_IN;
        end
      end
      S_IN: begin
        in_ready = 1'b1;
        if (in_xfer) begin
          pc_clr  = 1'b1;
          rf_rw   = 1'b1;
          get_reg = 1'b1;
          new_in  = 1'b1;
          lst_nxt = '0;
          if (ch_idx != CH_LAST) begin
            ch_nxt    = ch_idx + 1'b1;
            state_nxt = S_ALLOC;
          end else begin
            done      = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq: per-cycle vector table
// plus hand sequences for stalls, reset and small configs.
module tb_ctrl_seq;

  localparam logic [14:0] M_DONE = 15'h0001;
  localparam logic [14:0] M_BUSY = 15'h0002;
  localparam logic [14:0] M_OV   = 15'h0004;
  localparam logic [14:0] M_IR   = 15'h0008;
  localparam logic [14:0] M_NOUT = 15'h0010;
  localparam logic [14:0] M_NIN  = 15'h0020;
  localparam logic [14:0] M_GR   = 15'h0040;
  localparam logic [14:0] M_RW   = 15'h0080;
  localparam logic [14:0] M_RE   = 15'h0100;
  localparam logic [14:0] M_CNT  = 15'h0200;
  localparam logic [14:0] M_AI   = 15'h0400;
  localparam logic [14:0] M_HI   = 15'h0800;
  localparam logic [14:0] M_FE   = 15'h1000;
  localparam logic [14:0] M_PI   = 15'h2000;
  localparam logic [14:0] M_PC   = 15'h4000;

  localparam logic [14:0] P_IDLE  = 15'h0000;
  localparam logic [14:0] P_ALLOC = M_FE | M_HI | M_BUSY;
  localparam logic [14:0] P_LOAD  = M_AI | M_GR | M_BUSY;
  localparam logic [14:0] P_CONV  = M_CNT | M_BUSY;
  localparam logic [14:0] P_RES   = M_RE | M_RW | M_BUSY;
  localparam logic [14:0] P_ERR   = M_RW | M_BUSY;
  localparam logic [14:0] P_INCR  = M_PI | M_BUSY;
  localparam logic [14:0] P_OUTX  = M_OV | M_NOUT | M_BUSY;
  localparam logic [14:0] P_OUTS  = M_OV | M_BUSY;
  localparam logic [14:0] P_INX   = M_IR | M_PC | M_RW | M_GR
                                  | M_NIN | M_BUSY;
  localparam logic [14:0] P_INS   = M_IR | M_BUSY;

  typedef struct {
    logic        st;
    logic [14:0] exp;
    int          tap;
    int          lst;
    int          ch;
  } vec_t;

  logic clk = 1'b0;
  logic rst, start_a, start_b, err_en, in_valid, out_ready;

  logic a_in_ready, a_out_valid, a_pc_clr, a_pc_incr, a_fetch;
  logic a_h_init, a_a_init, a_cnt, a_res_err, a_rf_rw, a_get_reg;
  logic a_new_in, a_new_out, a_busy, a_done;
  logic [1:0] a_tap;
  logic [0:0] a_lst, a_ch;
  logic [14:0] a_vec;

  logic b_in_ready, b_out_valid, b_pc_clr, b_pc_incr, b_fetch;
  logic b_h_init, b_a_init, b_cnt, b_res_err, b_rf_rw, b_get_reg;
  logic b_new_in, b_new_out, b_busy, b_done;
  logic [0:0] b_tap, b_lst, b_ch;
  logic [14:0] b_vec;

  int n_checks = 0;
  int n_err = 0;
  vec_t tbl[22];

  always #5 clk = ~clk;

  ctrl_seq #(.NTAPS(4), .NLIST(2), .NCH(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .err_en(err_en),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .pc_clr(a_pc_clr), .pc_incr(a_pc_incr), .fetch(a_fetch),
    .h_init(a_h_init), .a_init(a_a_init), .cnt(a_cnt),
    .res_err(a_res_err), .rf_rw(a_rf_rw), .get_reg(a_get_reg),
    .new_in(a_new_in), .new_out(a_new_out),
    .tap_idx(a_tap), .lst_idx(a_lst), .ch_idx(a_ch),
    .busy(a_busy), .done(a_done)
  );

  ctrl_seq #(.NTAPS(1), .NLIST(1), .NCH(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .err_en(err_en),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .pc_clr(b_pc_clr), .pc_incr(b_pc_incr), .fetch(b_fetch),
    .h_init(b_h_init), .a_init(b_a_init), .cnt(b_cnt),
    .res_err(b_res_err), .rf_rw(b_rf_rw), .get_reg(b_get_reg),
    .new_in(b_new_in), .new_out(b_new_out),
    .tap_idx(b_tap), .lst_idx(b_lst), .ch_idx(b_ch),
    .busy(b_busy), .done(b_done)
  );

  assign a_vec = {a_pc_clr, a_pc_incr, a_fetch, a_h_init, a_a_init,
                  a_cnt, a_res_err, a_rf_rw, a_get_reg, a_new_in,
                  a_new_out, a_in_ready, a_out_valid, a_busy, a_done};
  assign b_vec = {b_pc_clr, b_pc_incr, b_fetch, b_h_init, b_a_init,
                  b_cnt, b_res_err, b_rf_rw, b_get_reg, b_new_in,
                  b_new_out, b_in_ready, b_out_valid, b_busy, b_done};

  function automatic vec_t mk(logic st, logic [14:0] e,
                              int t, int l, int c);
    vec_t v;
    v.st = st; v.exp = e; v.tap = t; v.lst = l; v.ch = c;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // drive one cycle's inputs at the falling edge, settle, return
  task automatic step(input logic sa, input logic e,
                      input logic o, input logic i, input logic sb);
    @(negedge clk);
    start_a = sa; err_en = e; out_ready = o; in_valid = i;
    start_b = sb;
    #1;
  endtask

  initial begin
    int done_c, nout, nin, ndone, ncnt, nrw, nerr, nres, pi_c, ix;
    bit found;

    tbl[0]  = mk(1'b1, P_IDLE,  0, 0, 0);
    tbl[1]  = mk(1'b0, P_ALLOC, 0, 0, 0);
    tbl[2]  = mk(1'b0, P_LOAD,  0, 0, 0);
    tbl[3]  = mk(1'b0, P_CONV,  0, 0, 0);
    tbl[4]  = mk(1'b0, P_CONV,  1, 0, 0);
    tbl[5]  = mk(1'b0, P_CONV,  2, 0, 0);
    tbl[6]  = mk(1'b0, P_CONV,  3, 0, 0);
    tbl[7]  = mk(1'b0, P_RES,   0, 0, 0);
    tbl[8]  = mk(1'b0, P_ERR,   0, 0, 0);
    tbl[9]  = mk(1'b0, P_INCR,  0, 0, 0);
    tbl[10] = mk(1'b0, P_ALLOC, 0, 1, 0);
    tbl[11] = mk(1'b0, P_LOAD,  0, 1, 0);
    tbl[12] = mk(1'b0, P_CONV,  0, 1, 0);
    tbl[13] = mk(1'b0, P_CONV,  1, 1, 0);
    tbl[14] = mk(1'b0, P_CONV,  2, 1, 0);
    tbl[15] = mk(1'b0, P_CONV,  3, 1, 0);
    tbl[16] = mk(1'b0, P_RES,   0, 1, 0);
    tbl[17] = mk(1'b0, P_ERR,   0, 1, 0);
    tbl[18] = mk(1'b0, P_INCR,  0, 1, 0);
    tbl[19] = mk(1'b0, P_OUTX,  0, 1, 0);
    tbl[20] = mk(1'b0, P_INX,   0, 1, 0);
    tbl[21] = mk(1'b0, P_ALLOC, 0, 0, 1);

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    err_en = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_vec_a", int'(a_vec), int'(P_IDLE));
    chk("reset_vec_b", int'(b_vec), int'(P_IDLE));
    chk("reset_idx_a", int'({a_tap, a_lst, a_ch}), 0);

    // err_en=1, no stalls: cycle-by-cycle through channel 0
    for (int r = 0; r < 22; r++) begin
      step(tbl[r].st, 1'b1, 1'b1, 1'b1, 1'b0);
      chk($sformatf("tbl%0d_vec", r), int'(a_vec), int'(tbl[r].exp));
      chk($sformatf("tbl%0d_tap", r), int'(a_tap), tbl[r].tap);
      chk($sformatf("tbl%0d_lst", r), int'(a_lst), tbl[r].lst);
      chk($sformatf("tbl%0d_ch", r), int'(a_ch), tbl[r].ch);
    end

    // channel 1 to end of frame
    done_c = -1; nout = 0; nin = 0; ndone = 0;
    for (int c = 22; c < 80; c++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      nout += int'(a_new_out);
      nin += int'(a_new_in);
      ndone += int'(a_done);
      if (a_done) begin
        done_c = c;
        break;
      end
    end
    chk("ch1_done_cycle", done_c, 40);
    chk("ch1_new_out", nout, 1);
    chk("ch1_new_in", nin, 1);
    chk("ch1_done_cnt", ndone, 1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("post_done_idle", int'(a_vec), int'(P_IDLE));

    // err_en=0 latched; err_en flips and start held mid-frame
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    done_c = -1; nrw = 0; nerr = 0; nres = 0;
    for (int c = 1; c < 80; c++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      nrw += int'(a_rf_rw);
      nres += int'(a_res_err);
      nerr += int'(a_rf_rw & ~a_res_err & ~a_new_in);
      if (a_done) begin
        done_c = c;
        break;
      end
    end
    chk("noerr_done_cycle", done_c, 36);
    chk("noerr_rf_rw", nrw, 6);
    chk("noerr_res", nres, 4);
    chk("noerr_err_state", nerr, 0);

    // held start is picked up on the IDLE cycle after done
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("held_start_idle", int'(a_vec), int'(P_IDLE));
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("held_start_alloc", int'(a_vec), int'(P_ALLOC));

    // output stall with in_valid asserted but ignored
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      if (a_out_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("stall_reached", int'(found), 1);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      ix = int'({a_tap, a_lst, a_ch});
      chk($sformatf("stall%0d_vec", c), int'(a_vec), int'(P_OUTS));
      chk($sformatf("stall%0d_idx", c), ix, 2);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("stall_release", int'(a_vec), int'(P_OUTX));
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("in_wait%0d", c), int'(a_vec), int'(P_INS));
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("in_xfer", int'(a_vec), int'(P_INX));

    // reset in CONV at tap 2
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      if (a_cnt && a_tap == 2'd2) begin
        found = 1'b1;
        rst = 1'b1;
        break;
      end
    end
    chk("conv_tap2_reached", int'(found), 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_vec", int'(a_vec), int'(P_IDLE));
    chk("midrst_idx", int'({a_tap, a_lst, a_ch}), 0);

    // full frame after the mid-frame reset
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    done_c = -1; nout = 0; nin = 0; ndone = 0; ncnt = 0;
    for (int c = 1; c < 80; c++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      nout += int'(a_new_out);
      nin += int'(a_new_in);
      ndone += int'(a_done);
      ncnt += int'(a_cnt);
      if (a_done) begin
        done_c = c;
        break;
      end
    end
    chk("rerun_done_cycle", done_c, 40);
    chk("rerun_cnt", ncnt, 16);
    chk("rerun_new_out", nout, 2);
    chk("rerun_new_in", nin, 2);
    chk("rerun_done_cnt", ndone, 1);

    // NTAPS=1, NLIST=1, NCH=1
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    done_c = -1; ncnt = 0; pi_c = -1; ix = 0;
    for (int c = 1; c < 30; c++) begin
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      ncnt += int'(b_cnt);
      ix |= int'({b_tap, b_lst});
      if (b_pc_incr) pi_c = c;
      if (b_done) begin
        done_c = c;
        break;
      end
    end
    chk("small_done_cycle", done_c, 8);
    chk("small_cnt", ncnt, 1);
    chk("small_pc_incr", pi_c, 6);
    chk("small_idx", ix, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("small_idle", int'(b_vec), int'(P_IDLE));

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
